spi_xfer_arbiter: RTL and testbench
===================================

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

Interface
REQ-001 The block SHALL have parameter GO_PULSE_LEN, default 7, giving the number of cycles spi_go is held high per transfer (legal range 1..15).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1023, giving the number of WAIT_DONE cycles before a transfer is abandoned (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each; a high level is a transfer request from requester 0/1.
REQ-006 The block SHALL have ports wdata0/wdata1, input, 32 bits each, holding the word to send for each requester.
REQ-007 The block SHALL have ports ack0/ack1, output, 1 bit each; each is a one-cycle completion pulse.
REQ-008 The block SHALL have ports rdata0/rdata1, output, 32 bits each, holding the word received for each requester.
REQ-009 The block SHALL have port spi_go, output, 1 bit, the transfer start level to the SPI engine.
REQ-010 The block SHALL have port spi_wdata, output, 32 bits, the word presented to the SPI engine.
REQ-011 The block SHALL have port spi_done, input, 1 bit, the engine's data_pack_ready level; its rising edge means the transfer is complete.
REQ-012 The block SHALL have port spi_rdata, input, 32 bits, the data read back from the engine.
REQ-013 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-014 The block SHALL have port owner, output, 1 bit, the index of the granted requester; it is valid while busy.
REQ-015 The block SHALL have port err, output, 1 bit, a timeout pulse.

Function
REQ-016 The state machine SHALL have states IDLE, ISSUE, WAIT_DONE and RESP; all outputs are registered.
REQ-017 In IDLE, a single active request SHALL be granted: owner is set, spi_wdata is loaded from that requester's wdata, and the next state is ISSUE.
REQ-018 When both requests are active in IDLE, the block SHALL grant the requester that was not granted last (round-robin pointer); after reset, requester 0 wins first.
REQ-019 In ISSUE, spi_go SHALL be high for exactly GO_PULSE_LEN consecutive cycles, starting the cycle after the grant, then the state moves to WAIT_DONE.
REQ-020 spi_done rising-edge detection SHALL compare spi_done against a one-cycle delayed copy.
REQ-021 A rising edge in ISSUE SHALL be latched (done_seen), so that WAIT_DONE exits on its first cycle.
REQ-022 A rising edge in WAIT_DONE (or done_seen) SHALL load rdata[owner] from spi_rdata and move the state to RESP.
REQ-023 In RESP, ack[owner] SHALL be high for one cycle, the round-robin pointer is updated, and the next state is IDLE; a new grant is possible on the following cycle.
REQ-024 A request dropped after grant SHALL NOT abort the transfer; the transfer completes and ack is still pulsed.
REQ-025 spi_done edges while in IDLE or RESP SHALL be ignored.
REQ-026 The non-owner's rdata SHALL never change during another requester's transfer.
REQ-027 A request held high through ack SHALL be treated as a new request in IDLE.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set: state IDLE, spi_go 0, spi_wdata 0, ack0/ack1 0, rdata0/rdata1 0, owner 0, busy 0, err 0, round-robin pointer to favour requester 0, done_seen 0, and the delayed spi_done copy 0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer without an ack, and spi_go SHALL be low on the next cycle.

Configuration
REQ-030 With SPI_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_DONE; on reaching TIMEOUT_CYCLES the block goes to RESP, pulses ack[owner] and err together for one cycle, and leaves rdata[owner] unchanged.
REQ-031 Without SPI_ARB_TIMEOUT_EN, the block SHALL wait in WAIT_DONE indefinitely, err SHALL be tied to 0, and no counter SHALL be instantiated.

Verification
REQ-032 Single request: req0=1 with wdata0=32'h12345678 -> spi_wdata=32'h12345678 and spi_go high for 7 cycles; then spi_done rises with spi_rdata=32'hA5A5A5A5 -> rdata0=32'hA5A5A5A5 and ack0 is a one-cycle pulse, with ack1 staying 0.
REQ-033 Contention: req0 and req1 held high for 3 transfers -> grants go 0,1,0 and owner matches each ack.
REQ-034 Early done: spi_done rises in the 3rd cycle of ISSUE -> spi_go still lasts 7 cycles, then ack follows within 2 cycles with no further edge.
REQ-035 Reset mid-operation: reset pulsed during WAIT_DONE -> all outputs return to their reset values and no ack is pulsed.
REQ-036 Timeout: with SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 and spi_done held at 0 -> ack and err pulse together after 16 WAIT_DONE cycles and rdata is unchanged; without the macro, busy stays high indefinitely.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Two-requester round-robin front end sharing one SPI engine.
// Define SPI_ARB_TIMEOUT_EN to abandon transfers stuck in WAIT_DONE.
module spi_xfer_arbiter #(
    parameter int GO_PULSE_LEN   = 7,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        spi_go,
    output logic [31:0] spi_wdata,
    input  logic        spi_done,
    input  logic [31:0] spi_rdata,
    output logic        busy,
    output logic        owner,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

    localparam logic [3:0] GO_LAST = 4'(GO_PULSE_LEN - 1);

    if (GO_PULSE_LEN < 1 || GO_PULSE_LEN > 15) begin : g_bad_go
        $error("GO_PULSE_LEN out of range");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_to
        $error("TIMEOUT_CYCLES out of range");
    end

    state_t      state_q, state_d;
    logic        go_d;
    logic [31:0] wdata_d;
    logic        ack0_d, ack1_d;
    logic [31:0] rdata0_d, rdata1_d;
    logic        owner_d, busy_d;
    logic        prio_q, prio_d;
    logic        done_seen_q, done_seen_d;
    logic        done_q;
    logic [3:0]  go_cnt_q, go_cnt_d;
    logic        rise, grant;

    assign rise  = spi_done & ~done_q;
    assign grant = (req0 & req1) ? prio_q : req1;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            err      <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err      <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        go_d        = spi_go;
        wdata_d     = spi_wdata;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;
        owner_d     = owner;
        busy_d      = busy;
        prio_d      = prio_q;
        done_seen_d = done_seen_q;
        go_cnt_d    = go_cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        err_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d     = grant;
                    wdata_d     = grant ? wdata1 : wdata0;
                    go_d        = 1'b1;
                    go_cnt_d    = '0;
                    done_seen_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
                    to_cnt_d    = '0;
`endif
                end
            end
            ISSUE: begin
                // an engine that finishes early must not be missed
                if (rise) done_seen_d = 1'b1;
                if (go_cnt_q == GO_LAST) begin
                    go_d    = 1'b0;
                    state_d = WAIT_DONE;
                end else begin
                    go_cnt_d = go_cnt_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (rise | done_seen_q) begin
                    done_seen_d = 1'b0;
                    state_d     = RESP;
                    ack0_d      = ~owner;
                    ack1_d      = owner;
                    if (owner) rdata1_d = spi_rdata;
                    else       rdata0_d = spi_rdata;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = RESP;
                    ack0_d  = ~owner;
                    ack1_d  = owner;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                prio_d  = ~owner;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            spi_go      <= 1'b0;
            spi_wdata   <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            owner       <= 1'b0;
            busy        <= 1'b0;
            prio_q      <= 1'b0;
            done_seen_q <= 1'b0;
            done_q      <= 1'b0;
            go_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            spi_go      <= go_d;
            spi_wdata   <= wdata_d;
            ack0        <= ack0_d;
            ack1        <= ack1_d;
            rdata0      <= rdata0_d;
            rdata1      <= rdata1_d;
            owner       <= owner_d;
            busy        <= busy_d;
            prio_q      <= prio_d;
            done_seen_q <= done_seen_d;
            done_q      <= spi_done;
            go_cnt_q    <= go_cnt_d;
        end
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized bench for spi_xfer_arbiter against a transaction-level model.
// Timeout behaviour follows SPI_ARB_TIMEOUT_EN when defined.
module tb_spi_xfer_arbiter;
    localparam int GO  = 7;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        spi_go;
    logic [31:0] spi_wdata;
    logic        spi_done = 1'b0;
    logic [31:0] spi_rdata = '0;
    logic        busy, owner, err;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          rr;
    logic [31:0] rd [2];

    spi_xfer_arbiter #(
        .GO_PULSE_LEN  (GO),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .spi_go   (spi_go),
        .spi_wdata(spi_wdata),
        .spi_done (spi_done),
        .spi_rdata(spi_rdata),
        .busy     (busy),
        .owner    (owner),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_go", 32'(spi_go), 0);
        check("rst_wdata", spi_wdata, 0);
        check("rst_ack", 32'({ack1, ack0}), 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        spi_done = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs();
        reset = 1'b0;
        rr = 1'b0;
        rd[0] = '0;
        rd[1] = '0;
    endtask

    // done_at: cycle after grant at which spi_done rises; 0 = never
    task automatic xfer(input bit r0, input bit r1, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [31:0] rv,
                        input int done_at, input bit hold);
        bit win, to, acked, bad;
        int k, ack_k, exp_k, i;
        win = (r0 && r1) ? rr : r1;
        to = (done_at == 0);
        if (to) exp_k = GO + 1 + TMO;
        else exp_k = (done_at + 1 > GO + 2) ? done_at + 1 : GO + 2;
        wdata0 = w0;
        wdata1 = w1;
        req0 = r0;
        req1 = r1;
        spi_rdata = $urandom;
        i = 0;
        while (!busy && i < 8) begin
            @(posedge clk); #1;
            i++;
        end
        check("grant", 32'(busy), 1);
        if (!busy) begin
            req0 = 1'b0;
            req1 = 1'b0;
            return;
        end
        check("owner", 32'(owner), 32'(win));
        check("spi_wdata", spi_wdata, win ? w1 : w0);
        k = 1;
        acked = 1'b0;
        bad = 1'b0;
        ack_k = 0;
        while (!acked && k <= 60) begin
            if (spi_go !== (k <= GO)) bad = 1'b1;
            if (busy !== 1'b1) bad = 1'b1;
            if ((win ? rdata0 : rdata1) !== rd[win ? 0 : 1]) bad = 1'b1;
            if (ack0 | ack1) begin
                acked = 1'b1;
                ack_k = k;
            end else begin
                if (k == 1 && !hold) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
                if (k == done_at) begin
                    spi_done = 1'b1;
                    spi_rdata = rv;
                end
                @(posedge clk); #1;
                k++;
            end
        end
        check("go_busy_shape", 32'(bad), 0);
`ifndef SPI_ARB_TIMEOUT_EN
        if (to) begin
            check("stuck_noack", 32'(acked), 0);
            check("stuck_busy", 32'(busy), 1);
            req0 = 1'b0;
            req1 = 1'b0;
            return;
        end
`endif
        check("acked", 32'(acked), 1);
        check("ack_cycle", ack_k, exp_k);
        check("ack_vec", 32'({ack1, ack0}), 32'(win ? 2'b10 : 2'b01));
        check("ack_owner", 32'(owner), 32'(win));
        check("err", 32'(err), 32'(to));
        if (!to) rd[win ? 1 : 0] = rv;
        check("rdata0", rdata0, rd[0]);
        check("rdata1", rdata1, rd[1]);
        rr = !win;
        spi_done = 1'b0;
        if (!hold) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end
        @(posedge clk); #1;
        check("ack_pulse", 32'({err, ack1, ack0}), 0);
        check("idle", 32'(busy), 0);
    endtask

    initial begin
        bit bad;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        rr = 1'b0;
        rd[0] = '0;
        rd[1] = '0;

        xfer(1, 0, 32'h12345678, 32'h0, 32'hA5A5A5A5, 10, 0);

        do_reset();
        for (int n = 0; n < 3; n++)
            xfer(1, 1, $urandom, $urandom, $urandom, 4, 1);
        req0 = 1'b0;
        req1 = 1'b0;

        xfer(1, 0, $urandom, $urandom, $urandom, 3, 0);
        xfer(0, 1, $urandom, $urandom, $urandom, 1, 0);
        xfer(1, 1, $urandom, $urandom, $urandom, GO, 0);
        xfer(0, 1, $urandom, $urandom, $urandom, GO + 1, 0);

        bad = 1'b0;
        spi_done = 1'b1;
        spi_rdata = $urandom;
        repeat (3) begin
            @(posedge clk); #1;
            if (busy | ack0 | ack1) bad = 1'b1;
        end
        check("idle_done_ignored", 32'(bad), 0);
        check("idle_rdata0", rdata0, rd[0]);
        check("idle_rdata1", rdata1, rd[1]);
        spi_done = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 30; n++) begin
            bit a, b, h;
            a = ($urandom_range(1, 0) == 1);
            b = ($urandom_range(1, 0) == 1);
            h = ($urandom_range(1, 0) == 1);
            if (!a && !b) a = 1'b1;
            xfer(a, b, $urandom, $urandom, $urandom,
                 int'($urandom_range(20, 1)), h);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;

        xfer(0, 1, $urandom, $urandom, $urandom, 0, 0);
`ifndef SPI_ARB_TIMEOUT_EN
        do_reset();
`endif

        req0 = 1'b1;
        wdata0 = $urandom;
        repeat (GO + 3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        req0 = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs();
        reset = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (busy | ack0 | ack1 | spi_go) bad = 1'b1;
        end
        check("post_rst_quiet", 32'(bad), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
